// File: rtl/data_io_upload.sv
// SPI-driven upload engine: streams bytes read from RAM out over SPI.
// The SPI side prefetches one byte ahead through a single-entry buffer.
`timescale 1ns/1ps
module data_io_upload #(
  parameter logic [24:0] START_ADDR = 25'h0,
  parameter logic [7:0]  CMD_RX     = 8'h56,
  parameter logic [7:0]  CMD_RX_DAT = 8'h57
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        ss,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  output logic        uploading,
  output logic        underrun,
  output logic        rd,
  output logic [24:0] a,
  input  logic [7:0]  din,
  input  logic        rd_ack
);

  typedef enum logic [1:0] {StCmd, StParam, StTxdat, StIgnore} spi_st_e;
  typedef enum logic [1:0] {RIdle, RReq, RFull} rd_st_e;

  spi_st_e     spi_st_q;
  rd_st_e      rd_st_q;
  logic [1:0]  sck_sync_q, ss_sync_q, sdi_sync_q;
  logic        sck_prev_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_in_q, shift_out_q, buf_q;
  logic [24:0] addr_q;
  logic        load_pend_q, req_pend_q, stale_q;

  logic       sck_rise, sck_fall, ss_act;
  logic [7:0] rx_byte;

  assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q[1] & sck_prev_q;
  assign ss_act   = ~ss_sync_q[1];
  assign rx_byte  = {shift_in_q[6:0], sdi_sync_q[1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q  <= 2'b00;
      ss_sync_q   <= 2'b11;
      sdi_sync_q  <= 2'b00;
      sck_prev_q  <= 1'b0;
      spi_st_q    <= StCmd;
      rd_st_q     <= RIdle;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 8'h00;
      shift_out_q <= 8'h00;
      buf_q       <= 8'h00;
      addr_q      <= START_ADDR;
      load_pend_q <= 1'b0;
      req_pend_q  <= 1'b0;
      stale_q     <= 1'b0;
      sdo         <= 1'b0;
      sdo_oe      <= 1'b0;
      uploading   <= 1'b0;
      underrun    <= 1'b0;
      rd          <= 1'b0;
      a           <= 25'h0;
    end else begin
      sck_sync_q <= {sck_sync_q[0], sck};
      ss_sync_q  <= {ss_sync_q[0], ss};
      sdi_sync_q <= {sdi_sync_q[0], sdi};
      sck_prev_q <= sck_sync_q[1];
      sdo_oe     <= ss_act;

      // Read side; SPI events below may override these assignments.
      unique case (rd_st_q)
        RIdle: begin
          if (req_pend_q) begin
            rd         <= 1'b1;
            a          <= addr_q;
            rd_st_q    <= RReq;
            req_pend_q <= 1'b0;
          end
        end
        RReq: begin
          if (rd_ack) begin
            rd <= 1'b0;
            if (stale_q) begin
              stale_q <= 1'b0;
              rd_st_q <= RIdle;
            end else begin
              buf_q   <= din;
              rd_st_q <= RFull;
            end
          end
        end
        default: ;
      endcase

      if (!ss_act) begin
        spi_st_q    <= StCmd;
        bit_cnt_q   <= 3'd0;
        load_pend_q <= 1'b0;
        sdo         <= 1'b0;
      end else begin
        if (sck_rise) begin
          shift_in_q <= rx_byte;
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            case (spi_st_q)
              StCmd: begin
                if (rx_byte == CMD_RX) begin
                  spi_st_q <= StParam;
                end else if (rx_byte == CMD_RX_DAT) begin
                  spi_st_q    <= StTxdat;
                  load_pend_q <= 1'b1;
                end else begin
                  spi_st_q <= StIgnore;
                end
              end
              StParam: begin
                if (rx_byte != 8'h00) begin
                  uploading  <= 1'b1;
                  addr_q     <= START_ADDR;
                  underrun   <= 1'b0;
                  req_pend_q <= 1'b1;
                  if (rd_st_q == RFull || (rd_st_q == RReq && rd_ack)) rd_st_q <= RIdle;
                  // A read already in flight targets the old address; drop its data.
                  stale_q <= (rd_st_q == RReq && !rd_ack) || (rd_st_q == RIdle && req_pend_q);
                end else begin
                  uploading  <= 1'b0;
                  req_pend_q <= 1'b0;
                end
                spi_st_q <= StIgnore;
              end
              StTxdat: load_pend_q <= 1'b1;
              default: ;
            endcase
          end
        end

        if (sck_fall && spi_st_q == StTxdat) begin
          if (load_pend_q) begin
            load_pend_q <= 1'b0;
            if (!uploading) begin
              shift_out_q <= 8'h00;
              sdo         <= 1'b0;
            end else if (rd_st_q == RFull) begin
              shift_out_q <= buf_q;
              sdo         <= buf_q[7];
              addr_q      <= addr_q + 25'd1;
              rd_st_q     <= RIdle;
              req_pend_q  <= 1'b1;
            end else begin
              shift_out_q <= 8'hFF;
              sdo         <= 1'b1;
              underrun    <= 1'b1;
            end
          end else begin
            shift_out_q <= {shift_out_q[6:0], 1'b0};
            sdo         <= shift_out_q[6];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_data_io_upload.sv
// Bench for data_io_upload: SPI master tasks, RAM models and queue scoreboards.
`timescale 1ns/1ps
module tb_data_io_upload;

  localparam int HALF = 60;

  logic clk, reset, sck, ss, sdi, rd_ack, wrap_en, ram_hold;
  logic [7:0] din;
  logic sdo, sdo_oe, uploading, underrun, rd;
  logic [24:0] a;
  logic ss_w, rd_ack_w, sdo_w, sdo_oe_w, uploading_w, underrun_w, rd_w;
  logic [7:0] din_w;
  logic [24:0] a_w;

  int n_total = 0;
  int n_bad = 0;
  int rd_rise_cnt = 0;
  logic [24:0] exp_addr[$];
  logic [24:0] exp_addr_w[$];
  logic [7:0] exp_byte[$];
  logic [7:0] exp_byte_w[$];
  logic [7:0] mem [0:7];

  assign ss_w = ss | ~wrap_en;

  data_io_upload dut (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi), .sdo(sdo), .sdo_oe(sdo_oe),
    .uploading(uploading), .underrun(underrun), .rd(rd), .a(a), .din(din), .rd_ack(rd_ack)
  );

  data_io_upload #(.START_ADDR(25'h1FFFFFF)) dut_w (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss_w), .sdi(sdi), .sdo(sdo_w),
    .sdo_oe(sdo_oe_w), .uploading(uploading_w), .underrun(underrun_w), .rd(rd_w), .a(a_w),
    .din(din_w), .rd_ack(rd_ack_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Main RAM: two-cycle latency, acks can be withheld.
  int lat = 0;
  always @(negedge clk) begin
    if (rd_ack) rd_ack = 1'b0;
    else if (rd && !ram_hold) begin
      if (lat == 1) begin
        rd_ack = 1'b1;
        din = mem[a[2:0]];
        lat = 0;
      end else lat++;
    end else lat = 0;
  end

  // Wrap-test RAM: one-cycle latency, data derived from the address.
  always @(negedge clk) begin
    if (rd_ack_w) rd_ack_w = 1'b0;
    else if (rd_w) begin
      rd_ack_w = 1'b1;
      din_w = a_w[7:0] ^ 8'h5A;
    end
  end

  logic rd_prev = 1'b0, rd_prev_w = 1'b0;
  always @(negedge clk) begin
    if (rd && !rd_prev) begin
      rd_rise_cnt++;
      if (exp_addr.size() == 0) check("rd_unexpected", 32'(a), 32'h7FFFFFFF);
      else check("rd_addr", 32'(a), 32'(exp_addr.pop_front()));
    end
    if (rd_w && !rd_prev_w) begin
      if (exp_addr_w.size() == 0) check("rdw_unexpected", 32'(a_w), 32'h7FFFFFFF);
      else check("rdw_addr", 32'(a_w), 32'(exp_addr_w.pop_front()));
    end
    rd_prev = rd;
    rd_prev_w = rd_w;
  end

  // Each bit: falling edge (DUT shifts), half period, sample sdo, rising edge.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                          output logic [7:0] rxw);
    rx = 8'h00;
    rxw = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      sck = 1'b0;
      sdi = tx[i];
      #HALF;
      rx[i] = sdo;
      rxw[i] = sdo_w;
      sck = 1'b1;
      #HALF;
    end
  endtask

  task automatic ss_open();
    ss = 1'b0;
    #HALF;
  endtask

  task automatic ss_close();
    #HALF;
    ss = 1'b1;
    #HALF;
    sck = 1'b0;
    #(HALF * 2);
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] rx, rxw;
    spi_xfer(tx, 8, rx, rxw);
  endtask

  task automatic recv_check();
    logic [7:0] rx, rxw;
    spi_xfer(8'h00, 8, rx, rxw);
    if (exp_byte.size() == 0) check("byte_unexpected", 32'(rx), 32'h100);
    else check("sdo_byte", 32'(rx), 32'(exp_byte.pop_front()));
    if (wrap_en) begin
      if (exp_byte_w.size() == 0) check("bytew_unexpected", 32'(rxw), 32'h100);
      else check("sdo_byte_w", 32'(rxw), 32'(exp_byte_w.pop_front()));
    end
  endtask

  initial begin
    logic [7:0] rx, rxw;
    int cnt_snap;
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h81; mem[3] = 8'h4E;
    mem[4] = 8'hD2; mem[5] = 8'h17; mem[6] = 8'h6B; mem[7] = 8'hF0;
    reset = 1'b1; sck = 1'b0; ss = 1'b1; sdi = 1'b0; rd_ack = 1'b0; din = 8'h00;
    rd_ack_w = 1'b0; din_w = 8'h00; wrap_en = 1'b0; ram_hold = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_sdo", 32'(sdo), 0);
    check("rst_sdo_oe", 32'(sdo_oe), 0);
    check("rst_uploading", 32'(uploading), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_rd", 32'(rd), 0);
    check("rst_a", 32'(a), 0);
    @(negedge clk);
    reset = 1'b0;
    wrap_en = 1'b1;
    repeat (4) @(negedge clk);

    // Start upload on both instances.
    exp_addr.push_back(25'h0);
    exp_addr_w.push_back(25'h1FFFFFF);
    ss_open();
    check("sdo_oe_active", 32'(sdo_oe), 1);
    send(8'h56);
    send(8'h01);
    ss_close();
    check("start_uploading", 32'(uploading), 1);
    check("start_uploading_w", 32'(uploading_w), 1);
    check("start_rd_done", 32'(rd), 0);
    check("sdo_oe_idle", 32'(sdo_oe), 0);

    // Stream three bytes; wrap instance crosses 1FFFFFF -> 0.
    for (int i = 1; i <= 3; i++) exp_addr.push_back(25'(i));
    for (int i = 0; i <= 2; i++) exp_addr_w.push_back(25'(i));
    exp_byte.push_back(8'hA5); exp_byte.push_back(8'h3C); exp_byte.push_back(8'h81);
    exp_byte_w.push_back(8'hA5); exp_byte_w.push_back(8'h5A); exp_byte_w.push_back(8'h5B);
    ss_open();
    send(8'h57);
    repeat (3) recv_check();
    ss_close();
    check("stream_underrun", 32'(underrun), 0);
    wrap_en = 1'b0;

    // Underrun: the read of address 4 is withheld for 20 sck periods.
    ram_hold = 1'b1;
    exp_addr.push_back(25'h4);
    exp_byte.push_back(8'h4E); exp_byte.push_back(8'hFF); exp_byte.push_back(8'hD2);
    ss_open();
    send(8'h57);
    recv_check();
    recv_check();
    check("underrun_set", 32'(underrun), 1);
    check("underrun_rd_held", 32'(rd), 1);
    check("underrun_addr_held", 32'(a), 32'h4);
    #(HALF * 8);
    ram_hold = 1'b0;
    exp_addr.push_back(25'h5);
    repeat (10) @(negedge clk);
    recv_check();
    ss_close();

    // Abort a data byte after 3 bits, then stop the upload.
    exp_addr.push_back(25'h6);
    ss_open();
    send(8'h57);
    spi_xfer(8'h00, 3, rx, rxw);
    ss_close();
    ss_open();
    send(8'h56);
    send(8'h00);
    ss_close();
    check("stop_uploading", 32'(uploading), 0);
    cnt_snap = rd_rise_cnt;
    exp_byte.push_back(8'h00);
    ss_open();
    send(8'h57);
    recv_check();
    ss_close();
    repeat (20) @(negedge clk);
    check("stopped_no_rd", 32'(rd_rise_cnt), 32'(cnt_snap));

    // Restart with acks withheld, then reset while the read is outstanding.
    ram_hold = 1'b1;
    exp_addr.push_back(25'h0);
    ss_open();
    send(8'h56);
    send(8'h01);
    ss_close();
    check("restart_underrun_clr", 32'(underrun), 0);
    for (int i = 0; i < 200 && !rd; i++) @(negedge clk);
    check("rd_before_reset", 32'(rd), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_drops_rd", 32'(rd), 0);
    check("reset_uploading", 32'(uploading), 0);
    check("reset_a", 32'(a), 0);
    @(negedge clk);
    reset = 1'b0;
    ram_hold = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_rd", 32'(rd), 0);

    check("addr_q_left", 32'(exp_addr.size()), 0);
    check("addr_w_q_left", 32'(exp_addr_w.size()), 0);
    check("byte_q_left", 32'(exp_byte.size()), 0);
    check("byte_w_q_left", 32'(exp_byte_w.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/data_io_upload.md
DATA_IO_UPLOAD -- requirements
Module: data_io_upload

Interface
REQ-001 SHALL have parameter START_ADDR, default 25'h0, first RAM address read at upload start.
REQ-002 SHALL have parameter CMD_RX, default 8'h56, upload start/stop command.
REQ-003 SHALL have parameter CMD_RX_DAT, default 8'h57, upload data-stream command.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sck  input  1  SPI clock from IO controller, asynchronous; mode 0.
REQ-007 ss  input  1  SPI select, active low, asynchronous.
REQ-008 sdi  input  1  SPI data in, MSB first.
REQ-009 sdo  output  1  SPI data out, MSB first.
REQ-010 sdo_oe  output  1  high while ss is low (synchronised).
REQ-011 uploading  output  1  upload session active.
REQ-012 underrun  output  1  sticky: a byte was sent before RAM data was ready.
REQ-013 rd  output  1  RAM read request, held until rd_ack.
REQ-014 a  output  25  RAM read address, stable while rd high.
REQ-015 din  input  8  RAM read data, valid in the rd_ack cycle.
REQ-016 rd_ack  input  1  one-cycle read completion strobe.

Function
REQ-017 sck, ss and sdi SHALL each pass a 2-flop synchroniser; edges are detected on the synchronised sck; clk SHALL be at least 8x sck.
REQ-018 ss high SHALL clear the bit counter and return the SPI FSM to CMD; sdo SHALL be 0 and sdo_oe 0.
REQ-019 SPI FSM states: CMD, PARAM, TXDAT, IGNORE; sdi is sampled on sck rising edges; sdo changes only on sck falling edges or on a CMD->TXDAT transition.
REQ-020 CMD: after 8 rising edges, a byte equal to CMD_RX SHALL go to PARAM, CMD_RX_DAT SHALL go to TXDAT, and any other value SHALL go to IGNORE.
REQ-021 PARAM: a complete nonzero byte SHALL set uploading=1, load the address to START_ADDR, clear underrun, discard the buffer and start a read; a zero byte SHALL clear uploading and cancel any unissued read. The FSM then goes to IGNORE.
REQ-022 TXDAT: at the start of each byte (on entry and after every 8th rising edge), at the next sck falling edge the shift register SHALL load the prefetch buffer if it is full, else 8'hFF with underrun set to 1; sdo = shift[7]; each following falling edge shifts left by one.
REQ-023 A buffer load from a full buffer SHALL mark the buffer empty, increment the address mod 2^25 (wrapping 25'h1FFFFFF->0), and request the next read.
REQ-024 An underrun load SHALL NOT advance the address; the pending read remains outstanding.
REQ-025 TXDAT while uploading=0 SHALL send 8'h00 and issue no reads.
REQ-026 Read FSM states: R_IDLE, R_REQ, R_FULL; a request in R_IDLE SHALL assert rd with a=address in the next cycle; rd_ack in R_REQ SHALL capture din and go to R_FULL; a buffer load SHALL return R_FULL->R_IDLE and issue the next request.
REQ-027 rd SHALL never deassert before rd_ack; an ss rise mid-read SHALL NOT abort the read.
REQ-028 A buffer load and rd_ack in the same cycle SHALL be impossible by construction: only one read is outstanding and loads happen only in R_FULL.
REQ-029 An ss rise mid-byte SHALL discard the partial byte; the address and buffer are unchanged.

Reset
REQ-030 Reset SHALL force sdo=0, sdo_oe=0, uploading=0, underrun=0, rd=0, a=0, read FSM R_IDLE, SPI FSM CMD, buffer empty, address START_ADDR.
REQ-031 Reset during an outstanding read SHALL drop rd immediately; a later rd_ack SHALL be ignored.

Verification
REQ-032 Start: CMD_RX, 0x01 -> uploading=1, rd with a=0; rd_ack din=0xA5 -> buffer full.
REQ-033 Stream: CMD_RX_DAT then 3 bytes, RAM returning 0xA5,0x3C,0x81 with 2-cycle latency -> sdo bytes A5,3C,81; a sequence 0,1,2,3; underrun=0.
REQ-034 Underrun: RAM acks withheld for 20 sck -> the byte sent is FF, underrun=1, address held; after the ack the next byte equals the delayed data.
REQ-035 Wrap: START_ADDR=25'h1FFFFFF, 2 bytes streamed -> reads at 1FFFFFF then 0000000.
REQ-036 Stop/abort: ss raised after 3 bits of a data byte, then CMD_RX 0x00 -> uploading=0, no further rd; reset asserted mid-read -> rd=0 next cycle.
